// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, S-box, MixColumns, round constants and FSM states.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

    localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (0 maps to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed on the last round), AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] sub;
    logic [127:0] shf;
    logic [127:0] mix;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sub[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
    end

    // Byte index is 4*col+row; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shf[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mix[127-32*c -: 32] = mix_column(shf[127-32*c -: 32]);
    end

    assign state_o = (last_i ? shf : mix) ^ rkey_i;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor, one round per clock with an on-the-fly key expander.
// Define AES_CTR_EN for counter mode (adds iCtrLoad/iCtr; output is E(K,ctr) ^ latched iBlock).
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_BITS-1:0] iKey,
    input  logic [127:0]        iBlock,
    input  logic                iValid,
    output logic                oReady,
    output logic [127:0]        oBlock,
    output logic                oValid,
    input  logic                iReady
`ifdef AES_CTR_EN
    ,
    input  logic                iCtrLoad,
    input  logic [127:0]        iCtr
`endif
);

    localparam int         NK = KEY_BITS / 32;
    localparam logic [3:0] NR = 4'(nr_of(KEY_BITS));

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    aes_state_e          st_q, st_d;
    logic [127:0]        state_q, state_d;
    logic [127:0]        blk_q, blk_d;
    logic [KEY_BITS-1:0] win_q, win_d, win_step;
    logic [3:0]          rnd_q, rnd_d;
    logic [127:0]        enc_in, pad, rnd_out, rkey;
    logic                accept, last;

    assign oReady = (st_q == IDLE);
    assign oValid = (st_q == DONE);
    assign oBlock = blk_q;
    assign accept = oReady & iValid;
    assign last   = (rnd_q == NR);

    // Key window: word 0 (oldest) sits at the MSB end, same order as iKey.
    logic [31:0] kw_t;
    logic [31:0] kw_n [4];
    logic [3:0]  rc_idx;
    logic [7:0]  rc;
    logic        rot;

    // AES-256 alternates: odd rounds produce a word index 8i (Rot+Sub+Rcon), even rounds 8i+4 (Sub only).
    assign rot    = (NK == 4) || rnd_q[0];
    assign rc_idx = (NK == 4) ? rnd_q - 4'd1 : (rnd_q - 4'd1) >> 1;
    assign rc     = (rc_idx < 4'd10) ? RCON[rc_idx] : 8'h00;
    assign kw_t   = rot ? (sub_word({win_q[23:0], win_q[31:24]}) ^ {rc, 24'h000000})
                        : sub_word(win_q[31:0]);

    assign kw_n[0] = win_q[KEY_BITS-1 -: 32] ^ kw_t;
    for (genvar i = 1; i < 4; i++) begin : g_kw
        assign kw_n[i] = win_q[KEY_BITS-1-32*i -: 32] ^ kw_n[i-1];
    end

    if (NK == 4) begin : g_win128
        assign win_step = {kw_n[0], kw_n[1], kw_n[2], kw_n[3]};
    end else begin : g_win256
        assign win_step = {win_q[KEY_BITS-129:0], kw_n[0], kw_n[1], kw_n[2], kw_n[3]};
    end

    assign rkey = win_step[KEY_BITS-1 -: 128];

    aes_round_comb u_round (
        .state_i (state_q),
        .rkey_i  (rkey),
        .last_i  (last),
        .state_o (rnd_out)
    );

`ifdef AES_CTR_EN
    logic [127:0] ctr_q, ctr_d;
    logic [127:0] ptl_q, ptl_d;

    assign enc_in = ctr_q;
    assign pad    = ptl_q;

    always_comb begin
        ctr_d = ctr_q;
        ptl_d = ptl_q;
        if (accept) begin
            ctr_d = ctr_q + 128'd1;
            ptl_d = iBlock;
        end
        if (iCtrLoad) ctr_d = iCtr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '0;
            ptl_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            ptl_q <= ptl_d;
        end
    end
`else
    assign enc_in = iBlock;
    assign pad    = '0;
`endif

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        win_d   = win_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        case (st_q)
            IDLE: begin
                if (accept) begin
                    state_d = enc_in ^ iKey[KEY_BITS-1 -: 128];
                    win_d   = iKey;
                    rnd_d   = 4'd1;
                    st_d    = ROUND;
                end
            end
            ROUND: begin
                state_d = rnd_out;
                win_d   = win_step;
                rnd_d   = rnd_q + 4'd1;
                if (last) begin
                    blk_d = rnd_out ^ pad;
                    rnd_d = '0;
                    st_d  = DONE;
                end
            end
            DONE: begin
                if (iReady) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            state_q <= '0;
            win_q   <= '0;
            rnd_q   <= '0;
            blk_q   <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            win_q   <= win_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: known-answer vectors plus random blocks against a byte-level FIPS-197 model.
module tb_aes_iter_core;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] key1  = '0;
    logic [255:0] key2  = '0;
    logic [127:0] pt    = '0;
    logic         iv1   = 1'b0;
    logic         iv2   = 1'b0;
    logic         rdy   = 1'b1;
    logic         sel   = 1'b0;
    logic         or1, or2, ov1, ov2;
    logic [127:0] ob1, ob2;
    logic         ordy, ov;
    logic [127:0] ob;
`ifdef AES_CTR_EN
    logic         cl  = 1'b0;
    logic [127:0] ctr = '0;
`endif

    int           n_chk = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [7:0]   rc_t [11];
    logic [127:0] mctr [2];
    logic [7:0]   p8, q8, x8;
    logic         rs;
    logic [255:0] rk;
    logic [127:0] rp, re, ea, eb;
    int           n, m;

    always #5 clk = ~clk;

    assign ordy = sel ? or2 : or1;
    assign ov   = sel ? ov2 : ov1;
    assign ob   = sel ? ob2 : ob1;

    aes_iter_core #(.KEY_BITS(128)) u_c128 (
        .clk(clk), .rst_n(rst_n), .iKey(key1), .iBlock(pt), .iValid(iv1),
        .oReady(or1), .oBlock(ob1), .oValid(ov1), .iReady(rdy)
`ifdef AES_CTR_EN
        , .iCtrLoad(cl), .iCtr(ctr)
`endif
    );

    aes_iter_core #(.KEY_BITS(256)) u_c256 (
        .clk(clk), .rst_n(rst_n), .iKey(key2), .iBlock(pt), .iValid(iv2),
        .oReady(or2), .oBlock(ob2), .oValid(ov2), .iReady(rdy)
`ifdef AES_CTR_EN
        , .iCtrLoad(cl), .iCtr(ctr)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Full key schedule up front, then rounds on a 16-byte array (index = 4*col+row).
    function automatic logic [127:0] aes_ref(input logic s, input logic [255:0] k, input logic [127:0] p);
        int           nk, nr;
        logic [31:0]  w [60];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [127:0] res;
        nk = s ? 8 : 4;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*nr+4; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc_t[i/nk], 24'h000000};
            else if (nk == 8 && i % nk == 4) tmp = subw(tmp);
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[st[i%4 + 4*((i/4 + i%4) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    st[4*c+j] = (r == nr) ? t[4*c+j]
                              : x2(t[4*c+j]) ^ x2(t[4*c+(j+1)%4]) ^ t[4*c+(j+1)%4]
                                ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Expected result of the next handshake on instance s; advances the counter model in CTR builds.
    task automatic exp_for(input logic s, input logic [255:0] k, input logic [127:0] p, output logic [127:0] e);
`ifdef AES_CTR_EN
        e = aes_ref(s, k, mctr[s]) ^ p;
        mctr[s] = mctr[s] + 128'd1;
`else
        e = aes_ref(s, k, p);
`endif
    endtask

    task automatic run_blk(input logic s, input logic [255:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input int hold);
        int cnt;
        int nr;
        nr   = s ? 14 : 10;
        sel  = s;
        pt   = p;
        key1 = k[255:128];
        key2 = k;
        rdy  = (hold == 0);
        if (s) iv2 = 1'b1;
        else   iv1 = 1'b1;
        #1;
        chk("rdy_idle", 128'(ordy), 128'd1);
        @(posedge clk); #1;
        iv1 = 1'b0;
        iv2 = 1'b0;
        chk("ov_after_hs", 128'(ov), 128'd0);
        chk("rdy_busy", 128'(ordy), 128'd0);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!ov && cnt < 40);
        chk("latency", 128'(cnt), 128'(nr));
        chk("ct", ob, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_ov", 128'(ov), 128'd1);
            chk("hold_ct", ob, exp);
            chk("hold_rdy", 128'(ordy), 128'd0);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("ov_drop", 128'(ov), 128'd0);
        chk("rdy_back", 128'(ordy), 128'd1);
        chk("ct_keep", ob, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        p8 = 8'h01;
        q8 = 8'h01;
        do begin
            p8 = p8 ^ {p8[6:0], 1'b0} ^ (p8[7] ? 8'h1b : 8'h00);
            q8 = q8 ^ {q8[6:0], 1'b0};
            q8 = q8 ^ {q8[5:0], 2'b00};
            q8 = q8 ^ {q8[3:0], 4'h0};
            if (q8[7]) q8 = q8 ^ 8'h09;
            x8 = q8 ^ {q8[6:0], q8[7]} ^ {q8[5:0], q8[7:6]} ^ {q8[4:0], q8[7:5]} ^ {q8[3:0], q8[7:4]};
            sb[p8] = x8 ^ 8'h63;
        end while (p8 != 8'h01);
        sb[0] = 8'h63;
        rc_t[0] = 8'h00;
        rc_t[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc_t[i] = x2(rc_t[i-1]);
        mctr[0] = '0;
        mctr[1] = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy128", 128'(or1), 128'd1);
        chk("rst_ov128", 128'(ov1), 128'd0);
        chk("rst_ob128", ob1, 128'd0);
        chk("rst_rdy256", 128'(or2), 128'd1);
        chk("rst_ov256", 128'(ov2), 128'd0);
        chk("rst_ob256", ob2, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 AES-128 vector
        re = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_CTR_EN
        exp_for(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h00112233445566778899aabbccddeeff, re);
`endif
        run_blk(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h00112233445566778899aabbccddeeff, re, 0);

        // Sink stalls for 5 cycles
        re = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_CTR_EN
        exp_for(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h3243f6a8885a308d313198a2e0370734, re);
`endif
        run_blk(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h3243f6a8885a308d313198a2e0370734, re, 5);

        // FIPS-197 AES-256 vector
        re = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_CTR_EN
        exp_for(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 128'h00112233445566778899aabbccddeeff, re);
`endif
        run_blk(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 128'h00112233445566778899aabbccddeeff, re, 0);

        // Back-to-back with iValid held high; iBlock changes during the rounds
        rk = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        exp_for(1'b0, rk, 128'h0123456789abcdef0011223344556677, ea);
        exp_for(1'b0, rk, 128'hfedcba98765432108899aabbccddeeff, eb);
        sel  = 1'b0;
        rdy  = 1'b1;
        key1 = rk[255:128];
        pt   = 128'h0123456789abcdef0011223344556677;
        iv1  = 1'b1;
        #1;
        chk("b2b_rdy0", 128'(ordy), 128'd1);
        @(posedge clk); #1;
        pt = 128'hfedcba98765432108899aabbccddeeff;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (ov) chk("b2b_ct0", ob, ea);
        end while (!ordy && n < 40);
        chk("b2b_interval", 128'(n + 1), 128'd12);
        @(posedge clk); #1;
        iv1 = 1'b0;
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (!ov && m < 40);
        chk("b2b_lat1", 128'(m), 128'd10);
        chk("b2b_ct1", ob, eb);
        @(posedge clk); #1;
        chk("b2b_drop", 128'(ov), 128'd0);

        // Reset part-way through the rounds
        sel  = 1'b0;
        key1 = rk[255:128];
        pt   = 128'h3243f6a8885a308d313198a2e0370734;
        iv1  = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ov", 128'(ov1), 128'd0);
        chk("abort_ob", ob1, 128'd0);
        chk("abort_rdy", 128'(or1), 128'd1);
        mctr[0] = '0;
        mctr[1] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("no_stale", 128'(ov1), 128'd0);
        exp_for(1'b0, rk, 128'h3243f6a8885a308d313198a2e0370734, re);
        run_blk(1'b0, rk, 128'h3243f6a8885a308d313198a2e0370734, re, 0);

        for (int it = 0; it < 6; it++) begin
            rs = it[0];
            rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_for(rs, rk, rp, re);
            run_blk(rs, rk, rp, re, int'($urandom_range(2, 0)));
        end

`ifdef AES_CTR_EN
        // SP 800-38A CTR-AES128 vectors, then counter wrap
        rk  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        cl  = 1'b1;
        ctr = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        @(posedge clk); #1;
        cl = 1'b0;
        mctr[0] = ctr;
        mctr[1] = ctr;
        run_blk(1'b0, rk, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h874d6191b620e3261bef6864990db6ce, 0);
        mctr[0] = mctr[0] + 128'd1;
        run_blk(1'b0, rk, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h9806f66b7970fdff8617187bb9fffdff, 0);
        mctr[0] = mctr[0] + 128'd1;
        cl  = 1'b1;
        ctr = '1;
        @(posedge clk); #1;
        cl = 1'b0;
        mctr[0] = ctr;
        mctr[1] = ctr;
        rp = 128'h00000000000000000000000000000000;
        exp_for(1'b0, rk, rp, re);
        run_blk(1'b0, rk, rp, re, 0);
        re = aes_ref(1'b0, rk, 128'd0);
        mctr[0] = mctr[0] + 128'd1;
        run_blk(1'b0, rk, rp, re, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
        $finish;
    end

endmodule
